// File: rtl/axi_rd_arbiter_if.sv
// Bundle of requester-side handshakes and the AXI AR/R channel pair
// used by the read arbiter. The master modport is the arbiter's view,
// the slave modport is the view of whatever surrounds it.
interface axi_rd_arbiter_if;
  // icache requester
  logic         icache_req;
  logic         icache_uncache;
  logic [31:0]  icache_addr;
  logic         icache_addr_ready;
  logic         icache_data_ready;
  logic [127:0] icache_rdata;
  // dcache requester
  logic         dcache_rd_req;
  logic [31:0]  dcache_rd_addr;
  logic         dcache_rd_rdy;
  logic         dcache_ret_valid;
  logic [127:0] dcache_ret_data;
  // uncached data requester
  logic         uncache_rd_req;
  logic [2:0]   uncache_rd_size;
  logic [31:0]  uncache_rd_addr;
  logic         uncache_rd_rdy;
  logic         uncache_ret_valid;
  logic [31:0]  uncache_ret_data;
  // AXI AR channel
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  // AXI R channel
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  // FSM state, for observation only
  logic [1:0]   dbg_state;

  modport master (
    input  icache_req, icache_uncache, icache_addr,
    output icache_addr_ready, icache_data_ready, icache_rdata,
    input  dcache_rd_req, dcache_rd_addr,
    output dcache_rd_rdy, dcache_ret_valid, dcache_ret_data,
    input  uncache_rd_req, uncache_rd_size, uncache_rd_addr,
    output uncache_rd_rdy, uncache_ret_valid, uncache_ret_data,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output dbg_state
  );

  modport slave (
    output icache_req, icache_uncache, icache_addr,
    input  icache_addr_ready, icache_data_ready, icache_rdata,
    output dcache_rd_req, dcache_rd_addr,
    input  dcache_rd_rdy, dcache_ret_valid, dcache_ret_data,
    output uncache_rd_req, uncache_rd_size, uncache_rd_addr,
    input  uncache_rd_rdy, uncache_ret_valid, uncache_ret_data,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  dbg_state
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Read-side scheduler sharing one AXI AR/R channel pair among the icache,
// the dcache and the uncached data path. One read is outstanding at a time:
// IDLE -> AR -> R -> DONE -> IDLE.
//
// Handshake semantics: a requester raises req with a stable payload and
// holds both until its rdy (addr_ready) is seen high in the same cycle;
// the transfer happens on that clock edge. AR follows AXI: the payload is
// stable while arvalid is high and transfers on arvalid && arready. R beats
// transfer on rvalid && rready. Return strobes are single-cycle pulses and
// need no acknowledge.
module axi_rd_arbiter #(
  parameter logic [3:0] ICACHE_ID  = 4'd0,
  parameter logic [3:0] DCACHE_ID  = 4'd1,
  parameter logic [3:0] UNCACHE_ID = 4'd2
) (
  input  logic            clk,
  input  logic            reset,
  axi_rd_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SRC_IC = 2'd0;
  localparam logic [1:0] SRC_DC = 2'd1;
  localparam logic [1:0] SRC_UC = 2'd2;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_src;
  logic [31:0]   r_addr;
  logic [2:0]    r_size;
  logic          r_uncached;
  logic [127:0]  r_buf;
  logic [2:0]    r_cnt;

  logic          w_idle;
  logic          w_gnt_ic;
  logic          w_gnt_dc;
  logic          w_gnt_uc;
  logic          w_grant;
  logic [3:0]    w_id;
  logic          w_beat_ok;
  logic          w_in_ar;

  // Fixed-priority grant, uncache > dcache > icache, only while idle and out of reset
  always_comb begin
    w_idle   = (r_state == S_IDLE) && !reset;
    w_gnt_uc = w_idle && bus.uncache_rd_req;
    w_gnt_dc = w_idle && bus.dcache_rd_req && !bus.uncache_rd_req;
    w_gnt_ic = w_idle && bus.icache_req && !bus.dcache_rd_req && !bus.uncache_rd_req;
    w_grant  = w_gnt_uc || w_gnt_dc || w_gnt_ic;
  end

  // AXI id of the latched source and acceptance of a matching R beat
  always_comb begin
    w_id = ICACHE_ID;
    if (r_src == SRC_UC) begin
      w_id = UNCACHE_ID;
    end else if (r_src == SRC_DC) begin
      w_id = DCACHE_ID;
    end
    w_beat_ok = (r_state == S_R) && bus.rvalid && (bus.rid == w_id);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant) w_next = S_AR;
      S_AR:   if (bus.arready) w_next = S_R;
      S_R:    if (w_beat_ok && bus.rlast) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch on grant, line buffer fill on accepted beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src      <= SRC_IC;
      r_addr     <= 32'd0;
      r_size     <= 3'd0;
      r_uncached <= 1'b0;
      r_buf      <= 128'd0;
      r_cnt      <= 3'd0;
    end else if (w_grant) begin
      r_buf <= 128'd0;
      r_cnt <= 3'd0;
      if (w_gnt_uc) begin
        r_src      <= SRC_UC;
        r_addr     <= bus.uncache_rd_addr;
        r_size     <= bus.uncache_rd_size;
        r_uncached <= 1'b1;
      end else if (w_gnt_dc) begin
        r_src      <= SRC_DC;
        r_addr     <= bus.dcache_rd_addr;
        r_size     <= 3'd2;
        r_uncached <= 1'b0;
      end else begin
        r_src      <= SRC_IC;
        r_addr     <= bus.icache_addr;
        r_size     <= 3'd2;
        r_uncached <= bus.icache_uncache;
      end
    end else if (w_beat_ok && (r_cnt < 3'd4)) begin
      // beats past the fourth are consumed but never stored
      r_buf[{r_cnt[1:0], 5'b00000} +: 32] <= bus.rdata;
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // AR/R channel outputs; AR payload is forced to zero outside the AR state
  always_comb begin
    w_in_ar     = (r_state == S_AR);
    bus.arvalid = w_in_ar;
    bus.araddr  = 32'd0;
    bus.arlen   = 8'd0;
    bus.arsize  = 3'd0;
    bus.arburst = 2'b00;
    bus.arid    = 4'd0;
    if (w_in_ar) begin
      bus.araddr  = r_uncached ? r_addr : {r_addr[31:4], 4'h0};
      bus.arlen   = r_uncached ? 8'd0 : 8'd3;
      bus.arsize  = r_size;
      bus.arburst = 2'b01;
      bus.arid    = w_id;
    end
    bus.rready    = (r_state == S_R);
    bus.dbg_state = r_state;
  end

  // Requester-side outputs: grants, return pulses from the DONE state, buffered data
  always_comb begin
    bus.uncache_rd_rdy    = w_gnt_uc;
    bus.dcache_rd_rdy     = w_gnt_dc;
    bus.icache_addr_ready = w_gnt_ic;
    bus.uncache_ret_valid = (r_state == S_DONE) && (r_src == SRC_UC);
    bus.dcache_ret_valid  = (r_state == S_DONE) && (r_src == SRC_DC);
    bus.icache_data_ready = (r_state == S_DONE) && (r_src == SRC_IC);
    bus.icache_rdata      = r_buf;
    bus.dcache_ret_data   = r_buf;
    bus.uncache_ret_data  = r_buf[31:0];
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Read-side scheduler that shares the single AXI AR/R channel pair among three requesters: instruction cache, data cache and uncached data path.
- Grants one requester at a time and issues the AXI address phase (4-beat line burst or single beat).
- Collects R beats into a 128-bit line buffer and returns the result to the granted requester.
- Sits between the caches and the AXI master port; the write channels are handled elsewhere.

Parameters:
ICACHE_ID, 4'd0, arid used for icache reads
DCACHE_ID, 4'd1, arid used for dcache line reads
UNCACHE_ID, 4'd2, arid used for uncached data reads

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
icache_req  in  1  icache read request
icache_uncache  in  1  icache request is uncached (single word)
icache_addr  in  32  icache read address
icache_addr_ready  out  1  icache request granted this cycle
icache_data_ready  out  1  one-cycle pulse, icache_rdata valid
icache_rdata  out  128  returned line, or word in [31:0]
dcache_rd_req  in  1  dcache line read request
dcache_rd_addr  in  32  dcache read address
dcache_rd_rdy  out  1  dcache request granted this cycle
dcache_ret_valid  out  1  one-cycle pulse, dcache_ret_data valid
dcache_ret_data  out  128  returned line
uncache_rd_req  in  1  uncached read request
uncache_rd_size  in  3  AXI size of the uncached read
uncache_rd_addr  in  32  uncached read address
uncache_rd_rdy  out  1  uncache request granted this cycle
uncache_ret_valid  out  1  one-cycle pulse, uncache_ret_data valid
uncache_ret_data  out  32  returned word
arid, araddr, arlen, arsize, arburst  out  4, 32, 8, 3, 2  AXI AR payload
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rid, rdata, rresp, rlast, rvalid  in  4, 32, 2, 1, 1  AXI R payload and valid
rready  out  1  AXI R ready

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on reset.
- Reset effect: state goes to IDLE, line buffer and beat counter clear, and every output is 0. Reset mid-transaction abandons the transaction; no ret_valid is produced for it.
- State machine: IDLE -> AR -> R -> DONE -> IDLE. Only one read is outstanding at a time.
- IDLE grant:
  - Priority is uncache > dcache > icache.
  - The winner's *_rdy / icache_addr_ready is asserted combinationally in the same cycle as its req, and only in IDLE with reset low.
  - On grant, latch source, address, size and the cached/uncached flag, clear the buffer and beat counter, then go to AR.
  - Losers must hold their req; nothing is queued for them.
- AR state:
  - arvalid=1, arburst=2'b01.
  - Cached read (dcache, or icache with uncache=0): araddr={addr[31:4],4'b0}, arlen=3, arsize=2.
  - Uncached read: araddr=addr, arlen=0. arsize=uncache_rd_size for the uncache path, 2 for an uncached icache read.
  - arid comes from the ID parameters.
  - arvalid stays high with a stable payload until arready; on arvalid&&arready go to R.
- R state:
  - rready=1.
  - A beat is accepted on rvalid with rid equal to the latched id. Mismatched-rid beats are consumed and dropped.
  - Accepted beat k is written to buffer[32k+31:32k] and the counter increments.
  - Beats after the 4th without rlast are dropped.
  - rresp is ignored.
  - An accepted beat with rlast goes to DONE.
- DONE state:
  - Registered one-cycle pulse on the granted source's ret_valid/data_ready, with data = buffer (uncache_ret_data = buffer[31:0]).
  - Unfilled slots read as 0 (early rlast, or uncached icache upper bits).
  - Next state is IDLE; a new grant is possible in the cycle after DONE.
- Data outputs hold their value until the next grant clears the buffer.
- Minimum latency with arready=1 and back-to-back rvalid: grant at T, AR at T+1, beats T+2..T+5, ret_valid at T+6 for a line. Single-beat reads give ret_valid at T+3.
- Back-to-back: after DONE, the pending highest-priority requester wins at the first IDLE cycle.

Test Plan:
1. dcache_rd_req, addr 0x1FC0_0124, arready=1, 4 beats 0xA..0xD (rlast on the 4th) -> dcache_rd_rdy at T; araddr=0x1FC0_0120, arlen=3, arsize=2, arid=1; dcache_ret_valid at T+6 with data 0x..D_..C_..B_..A.
2. All three reqs asserted in the same cycle -> uncache granted first, then dcache, then icache in successive IDLE windows; exactly one ret pulse per grant.
3. icache_uncache=1, addr 0xBFC0_0004 -> arlen=0, arsize=2, araddr=0xBFC0_0004; icache_rdata={96'b0, beat0}.
4. arready held low for 5 cycles -> arvalid stays 1 with a stable payload; no rdy to any other requester.
5. rid=3 beat injected during a dcache read -> beat dropped, line data correct.
6. reset pulsed during R state -> all outputs 0 immediately; no ret_valid; a new request afterwards completes normally.
